// File: rtl/wb_stage.sv
// Registered RV32I writeback stage: selects the rd source and extracts load data.
// Waits on a variable-latency read-data handshake, then pulses the register-file write port.
module wb_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int PC_INC     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            sel,
  input  logic [XLEN-1:0]       alu_result,
  input  logic [XLEN-1:0]       pc,
  input  logic [XLEN-1:0]       imm,
  input  logic [REG_ADDR_W-1:0] rd_addr,
  input  logic                  reg_write,
  input  logic [2:0]            load_funct3,
  input  logic [XLEN-1:0]       mem_rdata,
  input  logic                  mem_rvalid,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]       rf_wdata,
  output logic                  busy
);

  typedef enum logic {IDLE, WAIT_MEM} state_t;

  state_t                  state, state_nxt;
  logic [REG_ADDR_W-1:0]   cap_rd_p0;
  logic                    cap_we_p0;
  logic [2:0]              cap_f3_p0;
  logic [1:0]              cap_off_p0;

  logic                    done;
  logic                    capture;
  logic [REG_ADDR_W-1:0]   waddr_nxt;
  logic                    we_nxt;
  logic [XLEN-1:0]         wdata_nxt;
  logic [XLEN-1:0]         src_result;

  function automatic logic [XLEN-1:0] load_extract(input logic [XLEN-1:0] word,
                                                   input logic [2:0]      f3,
                                                   input logic [1:0]      off);
    logic [XLEN-1:0]    shifted;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    shifted = word >> {off, 3'b000};
    b       = shifted[7:0];
    h       = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  return XLEN'(b);
      3'b100:  return XLEN'($unsigned(b));
      3'b001:  return XLEN'(h);
      3'b101:  return XLEN'($unsigned(h));
      default: return word;
    endcase
  endfunction

  // Link and PC-relative sums wrap modulo 2^XLEN by construction.
  always_comb begin
    case (sel)
      3'b000:  src_result = alu_result;
      3'b010:  src_result = pc + XLEN'(PC_INC);
      3'b011:  src_result = imm;
      3'b100:  src_result = pc + imm;
      default: src_result = '0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    capture   = 1'b0;
    waddr_nxt = rd_addr;
    we_nxt    = reg_write;
    wdata_nxt = src_result;
    case (state)
      IDLE: begin
        if (in_valid) begin
          if (sel == 3'b001) begin
            if (mem_rvalid) begin
              done      = 1'b1;
              wdata_nxt = load_extract(mem_rdata, load_funct3, alu_result[1:0]);
            end else begin
              capture   = 1'b1;
              state_nxt = WAIT_MEM;
            end
          end else begin
            done = 1'b1;
          end
        end
      end
      WAIT_MEM: begin
        waddr_nxt = cap_rd_p0;
        we_nxt    = cap_we_p0;
        wdata_nxt = load_extract(mem_rdata, cap_f3_p0, cap_off_p0);
        if (mem_rvalid) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign in_ready = (state == IDLE);
  assign busy     = (state == WAIT_MEM);

  // Stage boundary: FSM state and captured load context
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cap_rd_p0  <= '0;
      cap_we_p0  <= 1'b0;
      cap_f3_p0  <= '0;
      cap_off_p0 <= '0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        cap_rd_p0  <= rd_addr;
        cap_we_p0  <= reg_write;
        cap_f3_p0  <= load_funct3;
        cap_off_p0 <= alu_result[1:0];
      end
    end
  end

  // Stage boundary: register-file write port, x0 writes suppressed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= done && we_nxt && (waddr_nxt != '0);
      if (done) begin
        rf_waddr <= waddr_nxt;
        rf_wdata <= wdata_nxt;
      end
    end
  end

endmodule
